// File: rtl/mem_arb_pkg.sv
// Shared types and lane helpers for the I/D memory arbiter.
// Size encodings, port identifiers and byte-mask helper functions.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] wmask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << size_bytes(size)) - 16'd1;
    m = m << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Stateless byte-lane steering: store mask/data shift, load extract,
// fetch half-word select and misalignment detection.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  d_size,
  input  logic [2:0]  d_off,
  input  logic [63:0] d_wdata,
  input  logic [2:0]  i_off,
  input  logic [63:0] mem_rdata,
  output logic [7:0]  d_wmask,
  output logic [63:0] d_wdata_lane,
  output logic [63:0] d_load,
  output logic        d_misalign,
  output logic [31:0] i_word,
  output logic        i_misalign
);

  always_comb begin
    d_misalign   = (d_off & align_mask(d_size)) != 3'd0;
    i_misalign   = i_off[1:0] != 2'd0;
    d_wmask      = d_misalign ? '0 : wmask(d_size, d_off);
    d_wdata_lane = d_wdata << {d_off, 3'b000};
    d_load       = '0;
    if (!d_misalign)
      d_load = (mem_rdata >> {d_off, 3'b000}) & size_mask(d_size);
    i_word = '0;
    if (!i_misalign)
      i_word = i_off[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (I) and data (D) ports with registered responses.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise D has fixed priority over I.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WID = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_WID+2:0] i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  input  logic                i_rready,
  output logic [31:0]         i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [1:0]          d_size,
  input  logic [ADDR_WID+2:0] d_addr,
  input  logic [63:0]         d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  input  logic                d_rready,
  output logic [63:0]         d_rdata,
  output logic                d_err,
  output logic [ADDR_WID-1:0] mem_addr,
  output logic                mem_wr_en,
  output logic [63:0]         mem_wdata,
  output logic [7:0]          mem_wmask,
  input  logic [63:0]         mem_rdata
);

  logic        i_elig;
  logic        d_elig;
  logic        i_sel;
  logic        d_sel;
  logic [7:0]  lane_wmask;
  logic [63:0] lane_wdata;
  logic [63:0] lane_load;
  logic        d_mis;
  logic [31:0] lane_iword;
  logic        i_mis;

`ifdef MEM_ARB_RR_EN
  port_e last_gnt;
`endif

  mem_lane_align u_align (
    .d_size       (d_size),
    .d_off        (d_addr[2:0]),
    .d_wdata      (d_wdata),
    .i_off        (i_addr[2:0]),
    .mem_rdata    (mem_rdata),
    .d_wmask      (lane_wmask),
    .d_wdata_lane (lane_wdata),
    .d_load       (lane_load),
    .d_misalign   (d_mis),
    .i_word       (lane_iword),
    .i_misalign   (i_mis)
  );

  // A port may be granted only if its response slot is empty or drains this cycle.
  always_comb begin
    i_elig = i_req && !(i_rvalid && !i_rready);
    d_elig = d_req && !(d_rvalid && !d_rready);
    d_sel  = d_elig;
    i_sel  = i_elig && !d_elig;
`ifdef MEM_ARB_RR_EN
    if (i_elig && d_elig) begin
      d_sel = (last_gnt == PORT_I);
      i_sel = !d_sel;
    end
`endif
    i_gnt = i_sel && !rst;
    d_gnt = d_sel && !rst;
  end

  always_comb begin
    mem_addr  = d_gnt ? d_addr[ADDR_WID+2:3] : i_addr[ADDR_WID+2:3];
    mem_wr_en = d_gnt && d_we && !d_mis;
    mem_wmask = mem_wr_en ? lane_wmask : '0;
    mem_wdata = lane_wdata;
  end

`ifdef MEM_ARB_RR_EN
  // Pointer only moves when both ports competed, so an idle partner does not steal a turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_gnt <= PORT_D;
    else if (i_elig && d_elig)
      last_gnt <= d_sel ? PORT_D : PORT_I;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      i_err    <= 1'b0;
    end else if (i_gnt) begin
      i_rvalid <= 1'b1;
      i_rdata  <= lane_iword;
      i_err    <= i_mis;
    end else if (i_rready) begin
      i_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else if (d_gnt) begin
      d_rvalid <= 1'b1;
      d_rdata  <= d_we ? '0 : lane_load;
      d_err    <= d_mis;
    end else if (d_rready) begin
      d_rvalid <= 1'b0;
    end
  end

endmodule
